// File: rtl/exe_stage.sv
// exe_stage: execute stage of the 5-stage pipeline. It holds the ALU, an iterative
//   shift-add multiplier and the BEQ resolver, and it drives the EXE/MEM register.
//   Latency: 1 cycle for single-cycle ops. MUL takes 34 cycles and exe_stall is high for the first 33.
//   Backpressure: exe_stall holds the upstream stages and inserts bubbles into EXE/MEM.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   e_*                      ID/EXE register fields (control, operands, immediate, pc4, dest, tags)
//   exe_stall, branch_taken, branch_target, exe_dest   combinational outputs
//   m_*                      EXE/MEM register outputs
module exe_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        e_wreg,
  input  logic        e_m2reg,
  input  logic        e_wmem,
  input  logic [3:0]  e_aluc,
  input  logic        e_shift,
  input  logic        e_aluimm,
  input  logic [31:0] e_data_a,
  input  logic [31:0] e_data_b,
  input  logic [31:0] e_imm,
  input  logic        e_branch,
  input  logic [31:0] e_pc4,
  input  logic        e_regrt,
  input  logic [4:0]  e_rt,
  input  logic [4:0]  e_rd,
  input  logic [3:0]  e_ins_type,
  input  logic [3:0]  e_ins_number,
  output logic        exe_stall,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic [4:0]  exe_dest,
  output logic        m_wreg,
  output logic        m_m2reg,
  output logic        m_wmem,
  output logic [31:0] m_alu,
  output logic [31:0] m_data_b,
  output logic [4:0]  m_dest,
  output logic [3:0]  m_ins_type,
  output logic [3:0]  m_ins_number
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] ALU_MUL = 4'b1011;
  localparam int CW = $clog2(MUL_CYCLES);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   mcand;
  logic [31:0]   mplier;
  logic [31:0]   product;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic [31:0]   alu_res;
  logic [31:0]   result;

  assign op_a = e_shift ? {27'b0, e_imm[10:6]} : e_data_a;
  assign op_b = e_aluimm ? e_imm : e_data_b;

  always_comb begin
    alu_res = '0;
    case (e_aluc)
      4'b0000: alu_res = op_a + op_b;
      4'b0001: alu_res = op_a - op_b;
      4'b0010: alu_res = op_a & op_b;
      4'b0011: alu_res = op_a | op_b;
      4'b0100: alu_res = op_a ^ op_b;
      4'b0101: alu_res = ~(op_a | op_b);
      4'b0110: alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      4'b0111: alu_res = op_b << op_a[4:0];
      4'b1000: alu_res = op_b >> op_a[4:0];
      4'b1001: alu_res = $unsigned($signed(op_b) >>> op_a[4:0]);
      4'b1010: alu_res = {op_b[15:0], 16'b0};
      default: alu_res = '0;
    endcase
  end

  // Only the DONE cycle ever lets a MUL result through to EXE/MEM.
  assign result = (state == S_DONE) ? product : alu_res;

  assign exe_stall     = (state == S_BUSY) | ((state == S_IDLE) & (e_aluc == ALU_MUL));
  assign exe_dest      = e_regrt ? e_rt : e_rd;
  assign branch_taken  = e_branch & (e_data_a == e_data_b) & ~exe_stall;
  assign branch_target = e_pc4 + {e_imm[29:0], 2'b00};

  // Multiplier FSM. A new MUL can start only from IDLE, so DONE always drains to IDLE first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (e_aluc == ALU_MUL) begin
            mcand   <= op_a;
            mplier  <= op_b;
            product <= '0;
            cnt     <= '0;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mplier[0]) product <= product + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(MUL_CYCLES - 1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // EXE/MEM register: a stalled cycle becomes an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst || exe_stall) begin
      m_wreg       <= 1'b0;
      m_m2reg      <= 1'b0;
      m_wmem       <= 1'b0;
      m_alu        <= '0;
      m_data_b     <= '0;
      m_dest       <= '0;
      m_ins_type   <= '0;
      m_ins_number <= '0;
    end else begin
      m_wreg       <= e_wreg;
      m_m2reg      <= e_m2reg;
      m_wmem       <= e_wmem;
      m_alu        <= result;
      m_data_b     <= e_data_b;
      m_dest       <= exe_dest;
      m_ins_type   <= e_ins_type;
      m_ins_number <= e_ins_number;
    end
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage pipelined CPU. Sits between the ID/EXE pipeline register and the MEM stage.
- Performs ALU operations, including a multi-cycle iterative 32-bit multiply, and resolves BEQ branches.
- Selects the destination register and registers all results into the EXE/MEM pipeline register.
- Raises exe_stall while a multiply is in progress so the upstream stages hold.

Parameters:
- MUL_CYCLES, 32, number of shift-add iterations for MUL; must equal the data width.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  synchronous, active-high reset
- e_wreg  input  1  instruction writes the register file
- e_m2reg  input  1  writeback source is memory
- e_wmem  input  1  instruction writes memory
- e_aluc  input  4  ALU operation code
- e_shift  input  1  operand A is the shamt, e_imm[10:6] zero-extended
- e_aluimm  input  1  operand B is e_imm
- e_data_a  input  32  rs value
- e_data_b  input  32  rt value
- e_imm  input  32  sign-extended immediate
- e_branch  input  1  instruction is BEQ
- e_pc4  input  32  PC+4 of the instruction
- e_regrt  input  1  destination is rt (1) or rd (0)
- e_rt  input  5  rt field
- e_rd  input  5  rd field
- e_ins_type  input  4  debug tag
- e_ins_number  input  4  debug tag
- exe_stall  output  1  hold the upstream stages (combinational)
- branch_taken  output  1  BEQ taken (combinational)
- branch_target  output  32  e_pc4 + (e_imm<<2) (combinational)
- exe_dest  output  5  current destination register, for hazard detection (combinational)
- m_wreg  output  1  registered
- m_m2reg  output  1  registered
- m_wmem  output  1  registered
- m_alu  output  32  ALU or MUL result
- m_data_b  output  32  store data (e_data_b)
- m_dest  output  5  destination register
- m_ins_type  output  4  debug tag
- m_ins_number  output  4  debug tag

Behaviour:
- Operand A is {27'b0, e_imm[10:6]} when e_shift, otherwise e_data_a. Operand B is e_imm when e_aluimm, otherwise e_data_b.
- aluc encoding (all results mod 2^32):
  - 0000 ADD
  - 0001 SUB (A-B)
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOR
  - 0110 SLT, signed, result 1 or 0
  - 0111 SLL (B<<A[4:0])
  - 1000 SRL
  - 1001 SRA
  - 1010 LUI ({B[15:0],16'b0})
  - 1011 MUL (low 32 bits of A*B, unsigned shift-add)
  - 1100-1111 give result 0
- exe_dest = e_regrt ? e_rt : e_rd.
- branch_taken = e_branch & (e_data_a == e_data_b) & ~exe_stall. The flush of younger instructions belongs to the upstream stages.
- MUL FSM, states IDLE, BUSY, DONE:
  - IDLE:
    - If e_aluc == 1011: exe_stall = 1, latch the multiplicand (A) and multiplier (B), clear the product, cnt = 0, go to BUSY.
    - Otherwise: exe_stall = 0 and the single-cycle result path is used.
  - BUSY:
    - exe_stall = 1.
    - Each cycle: if multiplier[0], product += multiplicand; then multiplicand <<= 1, multiplier >>= 1, cnt++.
    - When cnt == MUL_CYCLES-1 (after that iteration), go to DONE.
  - DONE:
    - exe_stall = 0.
    - m_alu captures the product. The other EXE/MEM fields capture the live inputs, which upstream holds stable.
    - Next state is IDLE.
- A MUL therefore occupies EXE for 1 + 32 + 1 = 34 cycles.
- Upstream requirement: while exe_stall = 1, the ID/EXE register and earlier stages hold. Inputs are stable for the whole MUL.
- EXE/MEM register, each rising edge:
  - If exe_stall = 1: capture a bubble. m_wreg, m_m2reg, m_wmem are 0; m_alu, m_data_b, m_dest, m_ins_type, m_ins_number are 0.
  - Otherwise: capture the live control signals, the result, e_data_b, exe_dest and the tags.
- Back-to-back MULs: DONE returns to IDLE. A second MUL presented in IDLE restarts the FSM. No MUL is ever started from DONE.
- Reset (synchronous, rst = 1 at a rising edge):
  - All m_* outputs go to 0.
  - FSM goes to IDLE; cnt, product and operand registers go to 0.
  - Reset wins over any operation, including mid-MUL. The partial product is discarded.
  - Combinational outputs follow the inputs, with exe_stall derived from the IDLE state.

Test Plan:
- rst=1 for 2 cycles, then 0 with idle inputs -> all m_* = 0, exe_stall = 0.
- ADD: aluc=0000, a=5, b=0xFFFFFFFF, aluimm=0, wreg=1, regrt=0, rd=7 -> next edge m_alu=4, m_dest=7, m_wreg=1, no stall.
- SRA: shift=1, imm[10:6]=4, b=0x80000000, aluc=1001 -> m_alu=0xF8000000. SLT with a=-1, b=1 -> m_alu=1.
- BEQ: e_branch=1, a=b=9, pc4=0x100, imm=0xFFFFFFFE -> branch_taken=1, branch_target=0x0F8. With a=9, b=8 -> branch_taken=0.
- MUL: a=0x12345, b=0x100 held stable:
  - exe_stall=1 for exactly 33 cycles, with bubbles (m_wreg=0) in EXE/MEM during that time.
  - Then m_alu=0x1234500 and m_wreg as presented.
  - a=0xFFFFFFFF, b=2 -> m_alu=0xFFFFFFFE.
- Assert rst at the 10th BUSY cycle of a MUL -> next edge: FSM IDLE, m_* = 0. With the MUL held on the inputs after reset, a fresh 34-cycle sequence follows with the correct product.
